// File: rtl/peripheral_adder_responder.sv
// Operand/result responder: accepts ip1/ip2 pairs, queues their full-width
// sums in a small FIFO and returns them in order, with saturating
// delivery/carry statistics.
module peripheral_adder_responder #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] ip1,
  input  logic [DATA_WIDTH-1:0] ip2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH:0]   out,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_WIDTH-1:0]  txn_count,
  output logic [CNT_WIDTH-1:0]  carry_count
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr, rd_ptr_inc;
  logic [AW:0]         occ, occ_nxt;
  logic [DATA_WIDTH:0] sum;
  logic                push, pop;

  // Handshake flags come straight from registered full/empty, so there is
  // no combinational path from in_valid/out_ready to the ready/valid outputs.
  assign in_ready   = ~full;
  assign out_valid  = ~empty;
  assign push       = in_valid & ~full;
  assign pop        = ~empty & out_ready;
  assign sum        = {1'b0, ip1} + {1'b0, ip2};
  assign rd_ptr_inc = rd_ptr + AW'(1);

  // Next occupancy: push/pop together leave it unchanged.
  always_comb begin
    occ_nxt = occ;
    case ({push, pop})
      2'b10:   occ_nxt = occ + (AW+1)'(1);
      2'b01:   occ_nxt = occ - (AW+1)'(1);
      default: occ_nxt = occ;
    endcase
  end

  // Result storage; stale writes during reset are harmless since pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sum;
  end

  // Pointers, occupancy flags, registered head-of-queue and counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      out         <= '0;
      txn_count   <= '0;
      carry_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr_inc;
      occ   <= occ_nxt;
      full  <= (occ_nxt == (AW+1)'(DEPTH));
      empty <= (occ_nxt == '0);
      // out mirrors the next head: the following stored entry after a pop,
      // or the incoming sum when it becomes the only entry.
      if (pop) begin
        if (occ > (AW+1)'(1)) out <= mem[rd_ptr_inc];
        else if (push)        out <= sum;
      end else if (empty && push) begin
        out <= sum;
      end
      if (pop) begin
        if (txn_count != '1) txn_count <= txn_count + CNT_WIDTH'(1);
        if (out[DATA_WIDTH] && carry_count != '1)
          carry_count <= carry_count + CNT_WIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_peripheral_adder_responder.sv
// Bench for peripheral_adder_responder: directed table, backpressure, streaming,
// mid-operation reset and random traffic against a queue-based model.
module tb_peripheral_adder_responder;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 4;  // narrow counters so saturation is reachable
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] ip1 = '0, ip2 = '0;
  logic          in_ready, out_valid, full, empty;
  logic [DW:0]   out;
  logic [CW-1:0] txn_count, carry_count;

  peripheral_adder_responder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ip1(ip1), .ip2(ip2), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .full(full), .empty(empty),
    .txn_count(txn_count), .carry_count(carry_count));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // reference: queue of pending sums plus saturating counters
  logic [DW:0] q[$];
  int m_txn = 0, m_carry = 0;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW:0]   sum;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // one clock: drive, update model at the edge, compare 1ns later
  task automatic cyc(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                     input logic r);
    bit do_push, do_pop;
    logic [DW:0] s;
    in_valid = v; ip1 = a; ip2 = b; out_ready = r;
    @(posedge clk);
    if (!rst) begin
      q.delete(); m_txn = 0; m_carry = 0;
    end else begin
      do_push = v && (q.size() < DEPTH);
      do_pop  = r && (q.size() > 0);
      if (do_pop) begin
        s = q.pop_front();
        if (m_txn < CMAX) m_txn++;
        if (s[DW] && m_carry < CMAX) m_carry++;
      end
      if (do_push) q.push_back(9'(a) + 9'(b));
    end
    #1;
    chk("in_ready", in_ready, q.size() < DEPTH);
    chk("out_valid", out_valid, q.size() != 0);
    chk("full", full, q.size() == DEPTH);
    chk("empty", empty, q.size() == 0);
    chk("txn_count", txn_count, m_txn);
    chk("carry_count", carry_count, m_carry);
    if (q.size() != 0) chk("out_head", out, q[0]);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) cyc(1'b0, '0, '0, 1'b0);
    rst = 1'b1;
  endtask

  logic [DW:0] held;

  initial begin
    tbl[0] = '{8'h12, 8'h34, 9'h046};
    tbl[1] = '{8'hFF, 8'h01, 9'h100};
    tbl[2] = '{8'hFF, 8'hFF, 9'h1FE};
    tbl[3] = '{8'h00, 8'h00, 9'h000};
    tbl[4] = '{8'h80, 8'h80, 9'h100};
    tbl[5] = '{8'h7F, 8'h01, 9'h080};

    // reset/idle
    do_reset(3);
    cyc(1'b0, '0, '0, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_txn", txn_count, 0);

    // table: one push then one pop per vector, 1-cycle latency
    foreach (tbl[i]) begin
      cyc(1'b1, tbl[i].a, tbl[i].b, 1'b1);
      chk("tbl_valid", out_valid, 1'b1);
      chk("tbl_sum", out, tbl[i].sum);
      cyc(1'b0, '0, '0, 1'b1);
      chk("tbl_empty_after_pop", empty, 1'b1);
    end
    chk("tbl_txn", txn_count, 6);
    chk("tbl_carry", carry_count, 3);

    // backpressure: 5 offers with out_ready low, only 4 fit
    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, DW'(8'h21 * (i + 1)), DW'(8'hE0 + i), 1'b0);
      if (i == 0) held = out;
      if (i == 3) begin
        chk("bp_full", full, 1'b1);
        chk("bp_in_ready", in_ready, 1'b0);
      end
    end
    chk("bp_stable", out, held);
    cyc(1'b1, 8'hA5, 8'h5A, 1'b1);          // pop only, full blocks push
    chk("bp_ready_back", in_ready, 1'b1);
    cyc(1'b1, 8'hA5, 8'h5A, 1'b0);          // 5th pair now accepted
    chk("bp_full_again", full, 1'b1);
    repeat (5) cyc(1'b0, '0, '0, 1'b1);
    chk("bp_drained", empty, 1'b1);

    // streaming push+pop, pointers wrap, then saturate counters
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, DW'($urandom), DW'($urandom), 1'b1);
      chk("stream_occ1", {full, empty}, 2'b00);
    end
    cyc(1'b0, '0, '0, 1'b1);
    chk("stream_txn", txn_count, 10);
    repeat (20) cyc(1'b1, 8'hFF, DW'($urandom), 1'b1);
    cyc(1'b0, '0, '0, 1'b1);
    chk("txn_saturated", txn_count, CMAX);

    // reset mid-operation with an operand presented
    do_reset(1);
    repeat (3) cyc(1'b1, 8'hF0, 8'h33, 1'b0);
    rst = 1'b0;
    cyc(1'b1, 8'h11, 8'h22, 1'b1);
    rst = 1'b1;
    chk("mid_rst_empty", empty, 1'b1);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_txn", txn_count, 0);
    repeat (3) begin
      cyc(1'b0, '0, '0, 1'b1);
      chk("no_stale", out_valid, 1'b0);
    end

    // random traffic with occasional resets
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 59) != 0);
      cyc(1'($urandom_range(0, 9) < 7), DW'($urandom), DW'($urandom),
          1'($urandom_range(0, 1)));
    end
    rst = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
